// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state encoding and default operand width for the
// sequential shift-add multiplier.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/mult_step.sv
// mult_step: one combinational shift-add iteration of the multiplier.
// The add keeps its carry so the shifted product never loses the top bit.
module mult_step import mult_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_prod,
    input  logic [WIDTH-1:0]   i_mcand,
    output logic [2*WIDTH-1:0] o_prod
);
    logic [WIDTH:0] w_sum;
    assign w_sum  = {1'b0, i_prod[2*WIDTH-1:WIDTH]} + (i_prod[0] ? {1'b0, i_mcand} : '0);
    assign o_prod = {w_sum, i_prod[WIDTH-1:1]};
endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: unsigned WIDTH x WIDTH sequential multiplier, one step per RUN cycle.
// Define MULT_SEQ_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module mult_sequencer import mult_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t             r_state, w_state_nxt;
    logic [2*WIDTH-1:0] r_prod, w_step, w_fin;
    logic [WIDTH-1:0]   r_mcand, r_hi, r_lo;
    logic [CW-1:0]      r_cnt;
    logic               w_last;

    mult_step #(.WIDTH(WIDTH)) u_step (
        .i_prod (r_prod),
        .i_mcand(r_mcand),
        .o_prod (w_step)
    );

`ifdef MULT_SEQ_EARLY_TERM_EN
    // Low bits still to be consumed after this step; if all zero, shift the rest out now.
    logic [WIDTH-1:0] w_mask;
    assign w_mask = {WIDTH{1'b1}} >> (r_cnt + 1'b1);
    assign w_last = (w_step[WIDTH-1:0] & w_mask) == '0;
    assign w_fin  = w_step >> (CW'(WIDTH - 1) - r_cnt);
`else
    assign w_last = r_cnt == CW'(WIDTH - 1);
    assign w_fin  = w_step;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == IDLE) ? (start ? RUN : IDLE) :
                      (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prod  <= '0;
            r_mcand <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (r_state == IDLE && start) begin
            r_prod  <= {{WIDTH{1'b0}}, op_b};
            r_mcand <= op_a;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_prod <= w_last ? w_fin : w_step;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) {r_hi, r_lo} <= w_fin;
        end
    end

    assign busy = r_state != IDLE;
    assign done = r_state == DONE;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; product is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 SHALL have port op_a, input, WIDTH bits: multiplicand, captured when start is accepted.
REQ-006 SHALL have port op_b, input, WIDTH bits: multiplier (initial product low half), captured when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port hi, output, WIDTH bits: upper half of the last completed product.
REQ-010 SHALL have port lo, output, WIDTH bits: lower half of the last completed product.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE after the final iteration; DONE->IDLE unconditionally after one cycle.
REQ-012 SHALL, on the edge accepting start, load product = {WIDTH zeros, op_b}, latch op_a, and clear the iteration counter.
REQ-013 SHALL perform one shift-add step per RUN edge: if product[0]=1, add op_a to the upper half as a (WIDTH+1)-bit sum; then shift right one bit with the carry entering bit 2*WIDTH-1.
REQ-014 SHALL treat operands as unsigned and produce the exact 2*WIDTH-bit product with no carry loss.
REQ-015 SHALL execute exactly WIDTH steps, entering DONE on the WIDTH-th RUN edge and loading hi/lo on that same edge.
REQ-016 SHALL assert done for exactly the one cycle in DONE; with WIDTH=32, done is high 32 cycles after the start-sampling edge.
REQ-017 SHALL ignore start while busy=1, including in the DONE cycle; operands are not re-latched.
REQ-018 SHALL accept a start asserted in the first IDLE cycle after DONE, giving a back-to-back period of WIDTH+2 cycles.
REQ-019 SHALL hold hi/lo stable from one completion to the next; op_a/op_b changes during RUN SHALL have no effect.

Reset
REQ-020 SHALL, on reset assertion at any time including mid-RUN, immediately force state IDLE, busy=0, done=0, hi=0, lo=0, and clear the product and counter.
REQ-021 SHALL discard any in-flight operation on reset; no done pulse follows reset release.

Configuration
REQ-022 SHALL use macro MULT_SEQ_EARLY_TERM_EN: when defined, at each RUN edge, if the unprocessed multiplier bits after that step are all zero, apply the remaining right shifts at once and enter DONE on that edge.
REQ-023 SHALL, with MULT_SEQ_EARLY_TERM_EN defined, give RUN length = max(1, 1 + index of the highest set bit of op_b) edges, with results identical to the full run.
REQ-024 SHALL, without MULT_SEQ_EARLY_TERM_EN, always run exactly WIDTH steps.

Structure
REQ-025 SHALL place the state enum (IDLE, RUN, DONE) and the default width constant in shared package mult_pkg.
REQ-026 SHALL implement the combinational single-iteration add/shift as sub-module mult_step, instantiated once.

Verification
REQ-027 SHALL cover: op_a=3, op_b=5, start for 1 cycle -> done high 32 cycles later (macro off), hi=0, lo=15, busy low in the next cycle.
REQ-028 SHALL cover: op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (carry retention).
REQ-029 SHALL cover: start with 2*3, then start held with 9*9 during RUN -> result hi=0, lo=6; no second done until 9*9 is re-issued from IDLE.
REQ-030 SHALL cover: reset asserted 10 cycles into RUN -> busy, done, hi, lo are 0 immediately; no done after release.
REQ-031 SHALL cover, with MULT_SEQ_EARLY_TERM_EN: op_a=7, op_b=1 -> done 1 cycle after the start edge, lo=7; op_b=0x80000000, op_a=2 -> 32 cycles, hi=1, lo=0.
REQ-032 SHALL cover: a start in the first IDLE cycle after done (4*4 then 5*5) -> lo=16 then lo=25, period 34 cycles.
